// File: rtl/cpu16_shift_pkg.sv
// Shared definitions for the CPU-16 multi-cycle shift unit: data widths and FSM encoding.
package cpu16_shift_pkg;

    localparam int DATA_W  = 16;
    localparam int SHAMT_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/seq_shift_left_shl1_step.sv
// Single-position left shift with zero fill; the bit leaving the MSB is returned as cout.
module shl1_step
    import cpu16_shift_pkg::*;
#(
    parameter int WIDTH = DATA_W
) (
    input  logic [WIDTH-1:0] x,
    output logic [WIDTH-1:0] y,
    output logic             cout
);

    assign {cout, y} = {x, 1'b0};

endmodule

// File: rtl/seq_shift_left.sv
// Multi-cycle left shifter (one bit per clock) with start/done handshake.
// Define SLL_OVF_EN to add the sticky signed-overflow output ovf.
module seq_shift_left
    import cpu16_shift_pkg::*;
#(
    parameter int WIDTH = DATA_W,
    parameter int SHW   = SHAMT_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [SHW-1:0]   shamt,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] out,
    output logic             carry
`ifdef SLL_OVF_EN
    ,
    output logic             ovf
`endif
);

    state_t           r_state;
    state_t           w_next;
    logic [SHW-1:0]   r_cnt;
    logic [WIDTH-1:0] r_sreg;
    logic             r_carry;
    logic [WIDTH-1:0] w_shift_y;
    logic             w_shift_c;
    logic             w_accept;

    // start is only honoured in IDLE; while busy it is dropped, not queued.
    assign w_accept = (r_state == ST_IDLE) && start;

    shl1_step #(.WIDTH(WIDTH)) u_step (
        .x    (r_sreg),
        .y    (w_shift_y),
        .cout (w_shift_c)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_next = (shamt == '0) ? ST_DONE : ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                // The last shift happens on the same edge that moves to DONE.
                if (r_cnt == SHW'(1)) begin
                    w_next = ST_DONE;
                end
            end
            ST_DONE:  w_next = ST_IDLE;
            default:  w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sreg  <= '0;
            r_cnt   <= '0;
            r_carry <= 1'b0;
        end else if (w_accept) begin
            r_sreg  <= a;
            r_cnt   <= shamt;
            r_carry <= 1'b0;
        end else if (r_state == ST_SHIFT) begin
            r_sreg  <= w_shift_y;
            r_carry <= w_shift_c;
            r_cnt   <= r_cnt - SHW'(1);
        end
    end

`ifdef SLL_OVF_EN
    logic r_ovf;
    logic r_sign;

    // Each shift moves sreg[WIDTH-2] into the sign position; any mismatch with the original sign overflows.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_ovf  <= 1'b0;
            r_sign <= 1'b0;
        end else if (w_accept) begin
            r_ovf  <= 1'b0;
            r_sign <= a[WIDTH-1];
        end else if ((r_state == ST_SHIFT) && (r_sreg[WIDTH-2] != r_sign)) begin
            r_ovf  <= 1'b1;
        end
    end

    assign ovf = r_ovf;
`endif

    assign busy  = (r_state != ST_IDLE);
    assign done  = (r_state == ST_DONE);
    assign out   = r_sreg;
    assign carry = r_carry;

endmodule
